// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle radix-2 restoring divider with E-stage stall control
//
// Executes DIV/DIVU in WIDTH iterations and freezes F/D/E while it runs.
// A pipeline flush (annul) abandons the operation.
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   div_validE             E stage holds DIV/DIVU (held stable while stalled)
//   div_signedE            1 = DIV (two's complement), 0 = DIVU
//   opaE, opbE             dividend, divisor
//   annul                  pipeline flush, aborts the operation
//   stall_divE             combinational stall request to the hazard unit
//   div_done               results valid this cycle
//   div_hi, div_lo         remainder, quotient (held until next completion)

module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_validE,
    input  logic             div_signedE,
    input  logic [WIDTH-1:0] opaE,
    input  logic [WIDTH-1:0] opbE,
    input  logic             annul,
    output logic             stall_divE,
    output logic             div_done,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} stateType;

    stateType       state;
    stateType       nextState;
    logic [CW-1:0]  counter;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divisorReg;
    logic           qNeg;
    logic           rNeg;

    logic           loadCalc;
    logic           loadZero;
    logic           finishCalc;

    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic [WIDTH-1:0] lowShift;
    logic             geq;
    logic [WIDTH-1:0] nextRem;
    logic [WIDTH-1:0] nextQuo;

    // Operand magnitudes; only signed operands with the sign bit set are negated.
    assign magA = (div_signedE && opaE[WIDTH-1]) ? -opaE : opaE;
    assign magB = (div_signedE && opbE[WIDTH-1]) ? -opbE : opbE;

    // One restoring step. The shifted partial remainder is WIDTH+1 bits wide;
    // when its top bit (remReg MSB) is set it certainly exceeds the divisor,
    // and the true difference always fits in WIDTH bits, so the low WIDTH
    // bits of the subtraction are exact.
    assign lowShift = {remReg[WIDTH-2:0], quoReg[WIDTH-1]};
    assign geq      = remReg[WIDTH-1] | (lowShift >= divisorReg);
    assign nextRem  = geq ? (lowShift - divisorReg) : lowShift;
    assign nextQuo  = {quoReg[WIDTH-2:0], geq};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        stall_divE = 1'b0;
        div_done   = 1'b0;
        loadCalc   = 1'b0;
        loadZero   = 1'b0;
        finishCalc = 1'b0;
        case (state)
            IDLE: begin
                if (div_validE && !annul) begin
                    stall_divE = 1'b1;
                    if (opbE == '0) begin
                        loadZero  = 1'b1;
                        nextState = DONE;
                    end else begin
                        loadCalc  = 1'b1;
                        nextState = CALC;
                    end
                end
            end
            CALC: begin
                if (annul) begin
                    nextState = IDLE;
                end else begin
                    stall_divE = 1'b1;
                    if (counter == LAST_COUNT) begin
                        finishCalc = 1'b1;
                        nextState  = DONE;
                    end
                end
            end
            DONE: begin
                // The instruction is still in E here; no restart from DONE.
                div_done  = ~annul;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter    <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            qNeg       <= 1'b0;
            rNeg       <= 1'b0;
            div_hi     <= '0;
            div_lo     <= '0;
        end else begin
            if (loadCalc) begin
                quoReg     <= magA;
                remReg     <= '0;
                divisorReg <= magB;
                qNeg       <= div_signedE & (opaE[WIDTH-1] ^ opbE[WIDTH-1]);
                rNeg       <= div_signedE & opaE[WIDTH-1];
                counter    <= '0;
            end
            if (state == CALC) begin
                remReg  <= nextRem;
                quoReg  <= nextQuo;
                counter <= counter + CW'(1);
            end
            // Results are taken from this cycle's final step, not the registers.
            if (finishCalc) begin
                div_lo <= qNeg ? -nextQuo : nextQuo;
                div_hi <= rNeg ? -nextRem : nextRem;
            end
            if (loadZero) begin
                div_lo <= '1;
                div_hi <= opaE;
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - scoreboard bench for div_sequencer

module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_validE = 1'b0;
    logic        div_signedE = 1'b0;
    logic [31:0] opaE = '0;
    logic [31:0] opbE = '0;
    logic        annul = 1'b0;
    logic        stall_divE;
    logic        div_done;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    div_sequencer #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .div_validE(div_validE),
        .div_signedE(div_signedE),
        .opaE(opaE),
        .opbE(opbE),
        .annul(annul),
        .stall_divE(stall_divE),
        .div_done(div_done),
        .div_hi(div_hi),
        .div_lo(div_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every completion must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && div_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("div_lo", {32'd0, div_lo}, {32'd0, e[63:32]});
                check("div_hi", {32'd0, div_hi}, {32'd0, e[31:0]});
            end
        end
    end

    // Called just after a rising edge; returns just after the edge ending DONE,
    // with div_validE still high so the caller may chain another divide.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expLo, input logic [31:0] expHi,
                           input int expStall);
        int stallCnt;
        bit seen;
        stallCnt = 0;
        seen = 0;
        div_validE = 1'b1;
        div_signedE = sgn;
        opaE = a;
        opbE = b;
        sb.push_back({expLo, expHi});
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (div_done) begin
                seen = 1;
                check("stall_in_done", {63'd0, stall_divE}, 64'd0);
                break;
            end
            if (stall_divE) stallCnt++;
        end
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        check("stall_cycles", 64'(stallCnt), 64'(expStall));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {63'd0, stall_divE}, 64'd0);
        check("rst_done", {63'd0, div_done}, 64'd0);
        check("rst_hilo", {div_hi, div_lo}, 64'd0);

        // annul while a DIV sits in IDLE suppresses the stall and the start
        @(posedge clk);
        #1 div_validE = 1'b1; opaE = 32'd5; opbE = 32'd1; annul = 1'b1;
        @(negedge clk);
        check("annul_idle_stall", {63'd0, stall_divE}, 64'd0);
        @(posedge clk);
        #1 div_validE = 1'b0; annul = 1'b0;
        @(negedge clk);
        check("annul_idle_nostart", {63'd0, stall_divE | div_done}, 64'd0);
        @(posedge clk);
        #1;

        run_div(1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 33);
        div_validE = 1'b0;
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        div_validE = 1'b0;
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33);
        div_validE = 1'b0;
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33);
        div_validE = 1'b0;
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33);
        div_validE = 1'b0;
        run_div(1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1);
        div_validE = 1'b0;

        // Annul part-way through CALC: no completion, results untouched
        @(posedge clk);
        #1 div_validE = 1'b1; div_signedE = 1'b0; opaE = 32'd1000; opbE = 32'd3;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk);
        check("annul_calc_stall", {63'd0, stall_divE}, 64'd0);
        check("annul_calc_done", {63'd0, div_done}, 64'd0);
        @(posedge clk);
        #1 annul = 1'b0; div_validE = 1'b0;
        @(negedge clk);
        check("annul_idle_after", {63'd0, stall_divE}, 64'd0);
        repeat (40) @(negedge clk);
        check("annul_keep_hilo", {div_hi, div_lo}, {32'h12345678, 32'hFFFFFFFF});
        @(posedge clk);
        #1;
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        div_validE = 1'b0;

        // Back-to-back: second DIV enters IDLE straight after DONE
        @(posedge clk);
        #1;
        run_div(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33);
        run_div(1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 33);
        div_validE = 1'b0;

        // Random operands against a behavioural model
        for (int k = 0; k < 6; k++) begin
            logic [31:0] a, b, q, r;
            logic s;
            a = $urandom;
            b = $urandom_range(1, 5000);
            if (k[0]) b = -b;
            s = k[1] | k[2];
            if (s) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
            @(posedge clk);
            #1;
            run_div(s, a, b, q, r, 33);
            div_validE = 1'b0;
        end

        // Reset in the middle of CALC
        @(posedge clk);
        #1 div_validE = 1'b1; div_signedE = 1'b0; opaE = 32'd50; opbE = 32'd7;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; div_validE = 1'b0;
        @(negedge clk);
        check("midrst_hilo", {div_hi, div_lo}, 64'd0);
        check("midrst_stall", {63'd0, stall_divE}, 64'd0);
        repeat (40) @(negedge clk);
        check("midrst_no_done_hilo", {div_hi, div_lo}, 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
